// File: rtl/adc_frame_gate_pkg.sv
// Shared types and constants for the ADC frame gate.
//   gate_state_t : frame gate FSM states
//   COUNT_W      : width of the delay/sample/gap counters and the frame/drop counters
package adc_frame_pkg;

  localparam int COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    CAPTURE,
    GAP
  } gate_state_t;

endpackage

// File: rtl/adc_frame_gate_if.sv
// AXI-Stream bundle used for both the ADC input and the frame output.
//   tvalid, tready, tdata[W-1:0], tlast, tstrb[W/8-1:0]
//   master : drives tvalid/tdata/tlast/tstrb, samples tready
//   slave  : samples tvalid/tdata/tlast/tstrb, drives tready
// Handshake: a beat transfers on a clock edge where tvalid and tready are both
// high. Once tvalid is raised, tdata/tlast hold steady until that transfer;
// tvalid never depends combinationally on tready.
interface adc_frame_gate_if #(
  parameter int W = 32
) ();

  logic           tvalid;
  logic           tready;
  logic [W-1:0]   tdata;
  logic           tlast;
  logic [W/8-1:0] tstrb;

  modport master (output tvalid, output tdata, output tlast, output tstrb, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tstrb, output tready);

endinterface

// File: rtl/adc_frame_gate_axis_out_reg.sv
// Single-entry AXI-Stream output register.
//   clk, rst       : clock, asynchronous active-high reset
//   load           : capture load_data/load_last into the register this cycle
//   load_data      : beat data to capture
//   load_last      : tlast value for the captured beat
//   ready          : downstream tready
//   force_last     : set tlast on the beat currently pending
//   tvalid/tlast/tdata : registered beat
//   full           : a beat is pending (same as tvalid)
module axis_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         ready,
  input  logic         force_last,
  output logic         tvalid,
  output logic         tlast,
  output logic [W-1:0] tdata,
  output logic         full
);

  assign full = tvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
      tdata  <= '0;
    end else if (load) begin
      // The caller only loads when empty or when the pending beat is taken
      // this same cycle, so overwriting here never loses a beat.
      tdata  <= load_data;
      tvalid <= 1'b1;
      tlast  <= load_last;
    end else if (tvalid && ready) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (force_last) begin
      // Final sample of the frame was dropped: close the frame on the beat
      // that is still waiting.
      tlast <= 1'b1;
    end
  end

endmodule

// File: rtl/adc_frame_gate.sv
// Trigger-gated framer: cuts the free-running ADC stream into one frame of
// SAMPLES_PER_TRIGGER beats per trigger rising edge, tlast on the final beat,
// with tvalid held low for at least MIN_GAP cycles between frames.
//   s00_axis_aclk, s00_axis_areset : clock, asynchronous active-high reset
//   s00_axis  (slave)  : ADC samples; tready tied high
//   m00_axis  (master) : frame beats; tstrb all ones
//   trig_in           : trigger level, rising edge starts a frame (IDLE only)
//   enable            : triggers accepted while high
//   frames_sent       : completed frames (counted on tlast handshake), wraps
//   overrun           : sticky, a sample was dropped behind a pending beat
//   busy              : FSM not in IDLE
//   state_dbg         : FSM state
//   drop_count        : dropped samples, saturating (only with DROP_COUNT_EN)
// Build option: define DROP_COUNT_EN to add the drop_count port and counter.
// The trigger edge cycle counts as the first delay cycle, so capture starts on
// the sample present TRIG_DELAY cycles after the edge (the edge cycle itself
// when TRIG_DELAY is 0). Input and output data widths must be equal.
module adc_frame_gate
  import adc_frame_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int SAMPLES_PER_TRIGGER    = 1000,
  parameter int TRIG_DELAY             = 0,
  parameter int MIN_GAP                = 1
) (
  input  logic                s00_axis_aclk,
  input  logic                s00_axis_areset,
  adc_frame_gate_if.slave     s00_axis,
  adc_frame_gate_if.master    m00_axis,
  input  logic                trig_in,
  input  logic                enable,
  output logic [COUNT_W-1:0]  frames_sent,
  output logic                overrun,
  output logic                busy,
  output gate_state_t         state_dbg
`ifdef DROP_COUNT_EN
  ,
  output logic [COUNT_W-1:0]  drop_count
`endif
);

  localparam logic [COUNT_W-1:0] LAST_IDX  = COUNT_W'(SAMPLES_PER_TRIGGER - 1);
  localparam logic [COUNT_W-1:0] DELAY_END = COUNT_W'(TRIG_DELAY - 1);
  localparam logic [COUNT_W-1:0] GAP_END   = COUNT_W'(MIN_GAP - 1);

  gate_state_t        state, state_nx;
  logic               trig_q;
  logic [COUNT_W-1:0] delay_cnt, sample_cnt, gap_cnt;
  logic               trig_edge, start, capture_slot, sample;
  logic               can_load, load, drop, is_last, out_full;
  logic               unused_in;

  assign unused_in = &{1'b0, s00_axis.tlast, s00_axis.tstrb,
                       C_S00_AXIS_TDATA_WIDTH == C_M00_AXIS_TDATA_WIDTH};

  assign s00_axis.tready = 1'b1;
  assign m00_axis.tstrb  = '1;

  assign trig_edge = trig_in & ~trig_q;
  assign start     = (state == IDLE) & trig_edge & enable;
  // With zero delay the edge cycle is already the first capture slot.
  assign capture_slot = (state == CAPTURE) | (start & (TRIG_DELAY == 0));
  assign sample    = capture_slot & s00_axis.tvalid;
  assign can_load  = ~out_full | m00_axis.tready;
  assign load      = sample & can_load;
  assign drop      = sample & ~can_load;
  assign is_last   = (sample_cnt == LAST_IDX);

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) state <= IDLE;
    else                 state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (TRIG_DELAY <= 1) ? CAPTURE : DELAY;
      DELAY:   if (delay_cnt == DELAY_END) state_nx = CAPTURE;
      CAPTURE: if (sample && is_last) state_nx = GAP;
      GAP:     if (!out_full && gap_cnt == GAP_END) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      trig_q      <= 1'b0;
      delay_cnt   <= '0;
      sample_cnt  <= '0;
      gap_cnt     <= '0;
      frames_sent <= '0;
      overrun     <= 1'b0;
    end else begin
      trig_q <= trig_in;
      case (state)
        IDLE: begin
          // Edge cycle counts as delay cycle 0.
          delay_cnt  <= start ? COUNT_W'(1) : '0;
          sample_cnt <= sample ? COUNT_W'(1) : '0;
          gap_cnt    <= '0;
        end
        DELAY: delay_cnt <= delay_cnt + COUNT_W'(1);
        CAPTURE: begin
          if (sample) sample_cnt <= is_last ? '0 : sample_cnt + COUNT_W'(1);
          gap_cnt <= '0;
        end
        GAP: begin
          // Gap is only measured once the last beat has left.
          if (out_full) gap_cnt <= '0;
          else          gap_cnt <= gap_cnt + COUNT_W'(1);
        end
        default: gap_cnt <= '0;
      endcase
      if (drop) overrun <= 1'b1;
      if (m00_axis.tvalid && m00_axis.tready && m00_axis.tlast)
        frames_sent <= frames_sent + COUNT_W'(1);
    end
  end

`ifdef DROP_COUNT_EN
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset)               drop_count <= '0;
    else if (drop && (drop_count != '1)) drop_count <= drop_count + COUNT_W'(1);
  end
`endif

  axis_out_reg #(.W(C_M00_AXIS_TDATA_WIDTH)) u_out (
    .clk        (s00_axis_aclk),
    .rst        (s00_axis_areset),
    .load       (load),
    .load_data  (s00_axis.tdata),
    .load_last  (is_last),
    .ready      (m00_axis.tready),
    .force_last (drop & is_last),
    .tvalid     (m00_axis.tvalid),
    .tlast      (m00_axis.tlast),
    .tdata      (m00_axis.tdata),
    .full       (out_full)
  );

endmodule

// File: tb/tb_adc_frame_gate.sv
// Bench for adc_frame_gate: two instances (TRIG_DELAY 0 and 3, 8 samples per
// frame, MIN_GAP 2) share a ramp ADC stream. A per-cycle vector table covers
// the first frame of both; hand sequences cover stalls, ignored edges, the
// inter-frame gap, mid-frame reset and enable removal.
module tb_adc_frame_gate;
  import adc_frame_pkg::*;

  localparam int W = 32;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         trig, en, rdy;
  logic [W-1:0] adc_data, adc_cnt, base;

  adc_frame_gate_if #(.W(W)) s0_if ();
  adc_frame_gate_if #(.W(W)) m0_if ();
  adc_frame_gate_if #(.W(W)) s3_if ();
  adc_frame_gate_if #(.W(W)) m3_if ();

  assign s0_if.tvalid = 1'b1;
  assign s0_if.tdata  = adc_data;
  assign s0_if.tlast  = 1'b0;
  assign s0_if.tstrb  = '1;
  assign s3_if.tvalid = 1'b1;
  assign s3_if.tdata  = adc_data;
  assign s3_if.tlast  = 1'b0;
  assign s3_if.tstrb  = '1;
  assign m0_if.tready = rdy;
  assign m3_if.tready = rdy;

  logic [15:0] fs0, fs3;
  logic        ov0, ov3, busy0, busy3;
  gate_state_t st0, st3;
`ifdef DROP_COUNT_EN
  logic [15:0] dc0, dc3;
`endif

  adc_frame_gate #(
    .SAMPLES_PER_TRIGGER (8),
    .TRIG_DELAY          (0),
    .MIN_GAP             (2)
  ) dut0 (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis        (s0_if),
    .m00_axis        (m0_if),
    .trig_in         (trig),
    .enable          (en),
    .frames_sent     (fs0),
    .overrun         (ov0),
    .busy            (busy0),
    .state_dbg       (st0)
`ifdef DROP_COUNT_EN
    ,
    .drop_count      (dc0)
`endif
  );

  adc_frame_gate #(
    .SAMPLES_PER_TRIGGER (8),
    .TRIG_DELAY          (3),
    .MIN_GAP             (2)
  ) dut3 (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis        (s3_if),
    .m00_axis        (m3_if),
    .trig_in         (trig),
    .enable          (en),
    .frames_sent     (fs3),
    .overrun         (ov3),
    .busy            (busy3),
    .state_dbg       (st3)
`ifdef DROP_COUNT_EN
    ,
    .drop_count      (dc3)
`endif
  );

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  logic        sb_on  = 1'b0;
  logic [32:0] exp_q[$];   // {tlast, tdata} of each expected dut0 beat

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_beat(input logic last, input logic [W-1:0] d);
    exp_q.push_back({last, d});
  endtask

  // driver: one clock cycle; inputs change 1 ns after the edge, and any dut0
  // handshake of this cycle is scored against the expected queue
  task automatic cyc(input logic t, input logic r, input logic e);
    logic [32:0] exp_beat;
    @(posedge clk);
    #1;
    trig     = t;
    rdy      = r;
    en       = e;
    adc_data = adc_cnt;
    adc_cnt  = adc_cnt + 1;
    if (sb_on && m0_if.tvalid && r) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat actual=%0h required=none", {m0_if.tlast, m0_if.tdata});
      end else begin
        exp_beat = exp_q.pop_front();
        chk("beat", {31'd0, m0_if.tlast, m0_if.tdata}, {31'd0, exp_beat});
      end
    end
  endtask

  typedef struct {
    logic        trig;
    logic        v0;
    logic        l0;
    logic [31:0] d0;
    logic        v3;
    logic        l3;
    logic [31:0] d3;
  } vec_t;

  vec_t vt[18];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // cycle k drives ramp sample k; trigger rises at cycle 5 and stays high
    vt[0]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 32'd5,  1'b0, 1'b0, 32'd0};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 32'd6,  1'b0, 1'b0, 32'd0};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 32'd7,  1'b0, 1'b0, 32'd0};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 32'd8,  1'b1, 1'b0, 32'd8};
    vt[10] = '{1'b1, 1'b1, 1'b0, 32'd9,  1'b1, 1'b0, 32'd9};
    vt[11] = '{1'b1, 1'b1, 1'b0, 32'd10, 1'b1, 1'b0, 32'd10};
    vt[12] = '{1'b1, 1'b1, 1'b0, 32'd11, 1'b1, 1'b0, 32'd11};
    vt[13] = '{1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 1'b0, 32'd12};
    vt[14] = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 32'd13};
    vt[15] = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 32'd14};
    vt[16] = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd15};
    vt[17] = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0};

    rst = 1'b1; trig = 1'b0; en = 1'b1; rdy = 1'b1;
    adc_data = '0; adc_cnt = '0; base = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_tvalid", m0_if.tvalid, 1'b0);
    chk("rst_tlast", m0_if.tlast, 1'b0);
    chk("rst_tdata", m0_if.tdata, 32'd0);
    chk("rst_frames", fs0, 16'd0);
    chk("rst_overrun", ov0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_tready", s0_if.tready, 1'b1);
    chk("tstrb", m0_if.tstrb, 4'hf);

    // first frame, table driven
    for (int k = 0; k < 18; k++) begin
      cyc(vt[k].trig, 1'b1, 1'b1);
      chk($sformatf("t%0d_v0", k), m0_if.tvalid, vt[k].v0);
      chk($sformatf("t%0d_l0", k), m0_if.tlast, vt[k].l0);
      if (vt[k].v0) chk($sformatf("t%0d_d0", k), m0_if.tdata, vt[k].d0);
      chk($sformatf("t%0d_v3", k), m3_if.tvalid, vt[k].v3);
      chk($sformatf("t%0d_l3", k), m3_if.tlast, vt[k].l3);
      if (vt[k].v3) chk($sformatf("t%0d_d3", k), m3_if.tdata, vt[k].d3);
    end
    chk("frames0_a", fs0, 16'd1);
    chk("frames3_a", fs3, 16'd1);
    chk("overrun_a", ov0, 1'b0);
    chk("busy_a", busy0, 1'b0);

    // stall for 2 cycles, edges in CAPTURE and on the tlast handshake, then
    // a second frame right after the minimum gap
    repeat (4) cyc(1'b0, 1'b1, 1'b1);
    sb_on = 1'b1;
    base = adc_cnt;
    push_beat(1'b0, base);
    push_beat(1'b0, base + 1);
    push_beat(1'b0, base + 2);
    push_beat(1'b0, base + 5);
    push_beat(1'b0, base + 6);
    push_beat(1'b1, base + 7);
    for (int j = 11; j < 18; j++) push_beat(1'b0, base + W'(j));
    push_beat(1'b1, base + 18);
    for (int i = 0; i < 21; i++) begin
      cyc((i == 0) || (i == 3) || (i == 8) || (i == 11), !((i == 3) || (i == 4)), 1'b1);
      if (i >= 9 && i <= 11) chk($sformatf("gap_low%0d", i), m0_if.tvalid, 1'b0);
      if (i == 12) chk("gap_rise", m0_if.tvalid, 1'b1);
    end
    chk("sb_empty_b", exp_q.size(), 0);
    chk("frames0_b", fs0, 16'd3);
    chk("overrun_b", ov0, 1'b1);
`ifdef DROP_COUNT_EN
    chk("drop_count_b", dc0, 16'd2);
`endif

    // reset during the fourth beat aborts the frame
    sb_on = 1'b0;
    repeat (4) cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(i == 0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("pre_rst_tvalid", m0_if.tvalid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", m0_if.tvalid, 1'b0);
    chk("mid_rst_tlast", m0_if.tlast, 1'b0);
    chk("mid_rst_frames", fs0, 16'd0);
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_overrun", ov0, 1'b0);
`ifdef DROP_COUNT_EN
    chk("mid_rst_drops", dc0, 16'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) cyc(1'b0, 1'b1, 1'b1);
    sb_on = 1'b1;
    base = adc_cnt;
    for (int j = 0; j < 8; j++) push_beat(j == 7, base + W'(j));
    for (int i = 0; i < 11; i++) cyc(i == 0, 1'b1, 1'b1);
    chk("sb_empty_c", exp_q.size(), 0);
    chk("frames0_c", fs0, 16'd1);

    // enable drops mid-frame: frame finishes, later edges are ignored
    repeat (2) cyc(1'b0, 1'b1, 1'b1);
    base = adc_cnt;
    for (int j = 0; j < 8; j++) push_beat(j == 7, base + W'(j));
    for (int i = 0; i < 11; i++) begin
      cyc(i == 0, 1'b1, i < 3);
      if (i == 5) chk("busy_no_en", busy0, 1'b1);
    end
    chk("sb_empty_d", exp_q.size(), 0);
    chk("frames0_d", fs0, 16'd2);
    for (int i = 0; i < 20; i++) cyc((i % 4) == 1, 1'b1, 1'b0);
    chk("idle_no_en", busy0, 1'b0);
    chk("frames0_e", fs0, 16'd2);
    chk("tvalid_no_en", m0_if.tvalid, 1'b0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
